systolic_ctrl: RTL and testbench

- Sequencer for the NxN INT8 systolic array of PE tiles.
- On a start command it:
  - clears the PE accumulators;
  - streams k_len operand vectors from the A (row) and B (column) operand buffers;
  - generates skewed row/column valid strobes;
  - waits for the wavefront to flush, then drains the N result rows with a valid/ready handshake.
- Sits between the tile-level command logic and the array plus its operand buffers.

---
 rtl/systolic_pkg.sv | 20 ++
 rtl/systolic_skew.sv | 28 ++
 rtl/systolic_ctrl.sv | 161 ++++++++++++++++
 tb/tb_systolic_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array sequencer.
package systolic_pkg;

    localparam int N_DEFAULT = 4;
    localparam int FLUSH_CYC = 2 * N_DEFAULT;

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        FLUSH,
        DRAIN,
        DONE
    } ctrl_state_t;

    // Wavefront flush length for an n x n array.
    function automatic int flush_cycles(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/systolic_skew.sv
// Valid delay line: tap i reproduces vld delayed by 1+i cycles.
module systolic_skew #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vld,
    output logic [N-1:0] taps
);

    logic [N-1:0] taps_q;
    logic [N-1:0] taps_d;

    always_comb begin
        taps_d = (taps_q << 1) | N'(vld);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            taps_q <= '0;
        end else begin
            taps_q <= taps_d;
        end
    end

    assign taps = taps_q;

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for the NxN systolic array: clear, feed operands, flush, drain results.
// state | meaning
// IDLE  | waiting for start
// FEED  | reading k_len operand vectors from A/B buffers
// FLUSH | letting the skewed wavefront pass through the array
// DRAIN | presenting result rows under valid/ready
// DONE  | one-cycle completion pulse
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int N      = N_DEFAULT,
    parameter int K_W    = 9,
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [K_W-1:0]       k_len,
    output logic                 busy,
    output logic                 done,
    output logic                 acc_clr,
    output logic                 a_rd_en,
    output logic [ADDR_W-1:0]    a_rd_addr,
    output logic                 b_rd_en,
    output logic [ADDR_W-1:0]    b_rd_addr,
    output logic [N-1:0]         row_vld,
    output logic [N-1:0]         col_vld,
    output logic                 out_vld,
    output logic [$clog2(N)-1:0] out_row,
    input  logic                 out_ready
);

    localparam int ROW_W = $clog2(N);
    localparam int FL_W  = $clog2(2 * N) + 1;
    localparam logic [FL_W-1:0] FLUSH_LOAD = FL_W'(flush_cycles(N));
    localparam logic [K_W-1:0]  K_MAX      = K_W'(2 ** ADDR_W);

    ctrl_state_t       state_q, state_d;
    logic [K_W-1:0]    feed_cnt_q, feed_cnt_d;
    logic [FL_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              acc_clr_q, acc_clr_d;
    logic              rd_en_q, rd_en_d;
    logic              out_vld_q, out_vld_d;
    logic [K_W-1:0]    k_eff;

    always_comb begin
        k_eff       = (k_len > K_MAX) ? K_MAX : k_len;
        state_d     = state_q;
        feed_cnt_d  = feed_cnt_q;
        flush_cnt_d = flush_cnt_q;
        row_d       = row_q;
        addr_d      = addr_q;
        acc_clr_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_clr_d  = 1'b1;
                    row_d      = '0;
                    addr_d     = '0;
                    feed_cnt_d = k_eff;
                    state_d    = (k_eff == '0) ? DRAIN : FEED;
                end
            end
            FEED: begin
                if (feed_cnt_q == K_W'(1)) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                    addr_d      = '0;
                end else begin
                    feed_cnt_d = feed_cnt_q - K_W'(1);
                    addr_d     = addr_q + ADDR_W'(1);
                end
            end
            FLUSH: begin
                if (flush_cnt_q == FL_W'(1)) begin
                    state_d = DRAIN;
                end else begin
                    flush_cnt_d = flush_cnt_q - FL_W'(1);
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (row_q == ROW_W'(N - 1)) begin
                        state_d = DONE;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they leave as flops.
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        rd_en_d   = (state_d == FEED);
        out_vld_d = (state_d == DRAIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            feed_cnt_q  <= '0;
            flush_cnt_q <= '0;
            row_q       <= '0;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            acc_clr_q   <= 1'b0;
            rd_en_q     <= 1'b0;
            out_vld_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            feed_cnt_q  <= feed_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            row_q       <= row_d;
            addr_q      <= addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            acc_clr_q   <= acc_clr_d;
            rd_en_q     <= rd_en_d;
            out_vld_q   <= out_vld_d;
        end
    end

    systolic_skew #(.N(N)) u_row_skew (
        .clk  (clk),
        .rst  (rst),
        .vld  (rd_en_q),
        .taps (row_vld)
    );

    systolic_skew #(.N(N)) u_col_skew (
        .clk  (clk),
        .rst  (rst),
        .vld  (rd_en_q),
        .taps (col_vld)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign acc_clr   = acc_clr_q;
    assign a_rd_en   = rd_en_q;
    assign b_rd_en   = rd_en_q;
    assign a_rd_addr = addr_q;
    assign b_rd_addr = addr_q;
    assign out_vld   = out_vld_q;
    assign out_row   = row_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl against a cycle-formula job model.
module tb_systolic_ctrl;

    localparam int N      = 4;
    localparam int K_W    = 9;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [K_W-1:0]    k_len = '0;
    logic              out_ready = 1'b0;
    logic              busy, done, acc_clr, a_rd_en, b_rd_en, out_vld;
    logic [ADDR_W-1:0] a_rd_addr, b_rd_addr;
    logic [N-1:0]      row_vld, col_vld;
    logic [1:0]        out_row;
    logic [31:0]       obs;

    always #5 clk = ~clk;

    systolic_ctrl #(.N(N), .K_W(K_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_len     (k_len),
        .busy      (busy),
        .done      (done),
        .acc_clr   (acc_clr),
        .a_rd_en   (a_rd_en),
        .a_rd_addr (a_rd_addr),
        .b_rd_en   (b_rd_en),
        .b_rd_addr (b_rd_addr),
        .row_vld   (row_vld),
        .col_vld   (col_vld),
        .out_vld   (out_vld),
        .out_row   (out_row),
        .out_ready (out_ready)
    );

    assign obs = {busy, done, acc_clr, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr,
                  row_vld, col_vld, out_vld, out_row};

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Job model: start cycle, effective length, rows accepted, cycle of last acceptance.
    bit have_job = 1'b0;
    int ts = 0;
    int jk = 0;
    int acc = 0;
    int last_acc = 0;

    function automatic int drain_start();
        return (jk == 0) ? ts + 1 : ts + jk + 1 + 2 * N;
    endfunction

    function automatic bit exp_drain(input int c);
        return have_job && (c >= drain_start()) && (acc < N);
    endfunction

    function automatic bit model_idle(input int c);
        return !have_job || (acc == N && c > last_acc + 1);
    endfunction

    function automatic logic [31:0] model_out(input int c);
        logic         bz, dn, clr, rd, ov;
        logic [7:0]   ad;
        logic [N-1:0] rv;
        logic [1:0]   rw;
        bz = 1'b0; dn = 1'b0; clr = 1'b0; rd = 1'b0; ov = 1'b0;
        ad = '0; rv = '0; rw = '0;
        if (have_job) begin
            clr = (c == ts + 1);
            rd  = (c >= ts + 1) && (c <= ts + jk);
            if (rd) ad = 8'(c - ts - 1);
            for (int i = 0; i < N; i++)
                rv[i] = (c >= ts + 2 + i) && (c <= ts + 1 + i + jk);
            ov = exp_drain(c);
            if (ov) rw = 2'(acc);
            dn = (acc == N) && (c == last_acc + 1);
            bz = (c >= ts + 1) && ((acc < N) || (c <= last_acc + 1));
        end
        return {bz, dn, clr, rd, rd, ad, ad, rv, rv, ov, rw};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Apply this cycle's inputs and advance the model to the end of the cycle.
    task automatic drive(input bit st, input int kl, input bit rdy, input bit rs);
        start     = st;
        k_len     = K_W'(kl);
        out_ready = rdy;
        rst       = rs;
        if (rs) begin
            have_job = 1'b0;
        end else begin
            if (exp_drain(cyc) && rdy) begin
                acc++;
                if (acc == N) last_acc = cyc;
            end
            if (st && model_idle(cyc)) begin
                have_job = 1'b1;
                ts       = cyc;
                jk       = (kl > 2 ** ADDR_W) ? 2 ** ADDR_W : kl;
                acc      = 0;
                last_acc = 0;
            end
        end
    endtask

    task automatic test_reset();
        for (int r = 0; r < 6; r++) begin
            next_cycle();
            vectors++;
            if (obs !== 32'h0) begin
                miscompares++;
                $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, obs, 32'h0);
            end
            drive((r < 3) ? 1'($urandom_range(0, 1)) : 1'b0, int'($urandom_range(0, 511)), 1'b1, r < 3);
        end
    endtask

    task automatic test_nominal();
        int t0, done_at, busy_n;
        t0 = -1; done_at = -1; busy_n = 0;
        for (int r = 0; r < 30; r++) begin
            next_cycle();
            vectors++;
            if (obs !== model_out(cyc)) begin
                miscompares++;
                $display("FAIL nominal cyc=%0d got=%h exp=%h", cyc, obs, model_out(cyc));
            end
            if (done) done_at = cyc;
            if (busy) busy_n++;
            if (r == 2) t0 = cyc;
            drive(r == 2, 3, 1'b1, 1'b0);
        end
        vectors++;
        if (done_at != t0 + 16) begin
            miscompares++;
            $display("FAIL nominal_done got=%0d exp=%0d", done_at, t0 + 16);
        end
        vectors++;
        if (busy_n != 16) begin
            miscompares++;
            $display("FAIL nominal_busy_cycles got=%0d exp=%0d", busy_n, 16);
        end
    endtask

    task automatic test_backpressure();
        int t0, done_at, k;
        bit rdy;
        t0 = -1; done_at = -1;
        k = int'($urandom_range(1, 8));
        for (int r = 0; r < 40; r++) begin
            next_cycle();
            vectors++;
            if (obs !== model_out(cyc)) begin
                miscompares++;
                $display("FAIL backpressure cyc=%0d got=%h exp=%h", cyc, obs, model_out(cyc));
            end
            if (done) done_at = cyc;
            if (r == 1) t0 = cyc;
            rdy = (t0 < 0) || !((cyc >= t0 + k + 1 + 2 * N) && (cyc < t0 + k + 4 + 2 * N));
            drive(r == 1, k, rdy, 1'b0);
        end
        vectors++;
        if (done_at != t0 + k + 16) begin
            miscompares++;
            $display("FAIL backpressure_done got=%0d exp=%0d", done_at, t0 + k + 16);
        end
    endtask

    task automatic test_start_busy();
        int t0, clr_n, clr_at, k2;
        bit st;
        int kl;
        t0 = -1; clr_n = 0; clr_at = -1;
        k2 = int'($urandom_range(0, 5));
        for (int r = 0; r < 50; r++) begin
            next_cycle();
            vectors++;
            if (obs !== model_out(cyc)) begin
                miscompares++;
                $display("FAIL start_busy cyc=%0d got=%h exp=%h", cyc, obs, model_out(cyc));
            end
            if (t0 >= 0 && acc_clr && cyc > t0) begin
                clr_n++;
                clr_at = cyc;
            end
            if (r == 1) t0 = cyc;
            st = 1'b0;
            kl = int'($urandom_range(0, 511));
            if (r == 1) begin
                st = 1'b1;
                kl = 3;
            end else if (t0 >= 0 && (cyc == t0 + 3 || cyc == t0 + 16)) begin
                st = 1'b1;
            end else if (t0 >= 0 && cyc == t0 + 17) begin
                st = 1'b1;
                kl = k2;
            end else if (t0 >= 0 && cyc > t0 && cyc < t0 + 16) begin
                st = ($urandom_range(0, 3) == 0);
            end
            drive(st, kl, 1'b1, 1'b0);
        end
        vectors++;
        if (clr_n != 2) begin
            miscompares++;
            $display("FAIL start_busy_clr_count got=%0d exp=%0d", clr_n, 2);
        end
        vectors++;
        if (clr_at != t0 + 18) begin
            miscompares++;
            $display("FAIL start_busy_second_clr got=%0d exp=%0d", clr_at, t0 + 18);
        end
    endtask

    task automatic test_zero_len();
        int t0, done_at, rd_n;
        t0 = -1; done_at = -1; rd_n = 0;
        for (int r = 0; r < 10; r++) begin
            next_cycle();
            vectors++;
            if (obs !== model_out(cyc)) begin
                miscompares++;
                $display("FAIL zero_len cyc=%0d got=%h exp=%h", cyc, obs, model_out(cyc));
            end
            if (done) done_at = cyc;
            if (a_rd_en || (row_vld != '0)) rd_n++;
            if (r == 1) t0 = cyc;
            drive(r == 1, 0, 1'b1, 1'b0);
        end
        vectors++;
        if (done_at != t0 + 5) begin
            miscompares++;
            $display("FAIL zero_len_done got=%0d exp=%0d", done_at, t0 + 5);
        end
        vectors++;
        if (rd_n != 0) begin
            miscompares++;
            $display("FAIL zero_len_reads got=%0d exp=%0d", rd_n, 0);
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        t0 = -1;
        for (int r = 0; r < 40; r++) begin
            next_cycle();
            vectors++;
            if (obs !== model_out(cyc)) begin
                miscompares++;
                $display("FAIL reset_mid cyc=%0d got=%h exp=%h", cyc, obs, model_out(cyc));
            end
            if (t0 >= 0 && cyc == t0 + 9) begin
                vectors++;
                if (obs !== 32'h0) begin
                    miscompares++;
                    $display("FAIL reset_mid_abort got=%h exp=%h", obs, 32'h0);
                end
            end
            if (t0 >= 0 && cyc == t0 + 11) begin
                vectors++;
                if ({acc_clr, a_rd_en, a_rd_addr} !== {1'b1, 1'b1, 8'h00}) begin
                    miscompares++;
                    $display("FAIL reset_mid_restart got=%h exp=%h",
                             {acc_clr, a_rd_en, a_rd_addr}, {1'b1, 1'b1, 8'h00});
                end
            end
            if (r == 1) t0 = cyc;
            drive((r == 1) || (t0 >= 0 && cyc == t0 + 10),
                  (r == 1) ? 3 : int'($urandom_range(1, 6)),
                  1'b1, (t0 >= 0 && cyc == t0 + 8));
        end
    endtask

    task automatic test_max_len();
        int kl_list[2];
        int rv3_n, rd_n, max_addr;
        kl_list[0] = 256;
        kl_list[1] = int'($urandom_range(257, 511));
        foreach (kl_list[j]) begin
            rv3_n = 0; rd_n = 0; max_addr = 0;
            for (int r = 0; r < 290; r++) begin
                next_cycle();
                vectors++;
                if (obs !== model_out(cyc)) begin
                    miscompares++;
                    $display("FAIL max_len cyc=%0d got=%h exp=%h", cyc, obs, model_out(cyc));
                end
                if (row_vld[N-1]) rv3_n++;
                if (a_rd_en) begin
                    rd_n++;
                    if (int'(a_rd_addr) > max_addr) max_addr = int'(a_rd_addr);
                end
                drive(r == 1, kl_list[j], 1'b1, 1'b0);
            end
            vectors++;
            if (rv3_n != 256) begin
                miscompares++;
                $display("FAIL max_len_row_vld3 k=%0d got=%0d exp=%0d", kl_list[j], rv3_n, 256);
            end
            vectors++;
            if (rd_n != 256 || max_addr != 255) begin
                miscompares++;
                $display("FAIL max_len_reads k=%0d got=%0d/%0d exp=256/255",
                         kl_list[j], rd_n, max_addr);
            end
        end
    endtask

    task automatic test_random();
        int kl;
        int guard;
        for (int r = 0; r < 1500; r++) begin
            next_cycle();
            vectors++;
            if (obs !== model_out(cyc)) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, model_out(cyc));
            end
            kl = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 511))
                                              : int'($urandom_range(0, 12));
            drive($urandom_range(0, 9) == 0, kl, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 199) == 0);
        end
        guard = 0;
        while (!model_idle(cyc) && guard < 600) begin
            next_cycle();
            vectors++;
            if (obs !== model_out(cyc)) begin
                miscompares++;
                $display("FAIL random_settle cyc=%0d got=%h exp=%h", cyc, obs, model_out(cyc));
            end
            drive(1'b0, 0, 1'b1, 1'b0);
            guard++;
        end
        next_cycle();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL random_idle_at_end got=%b exp=%b", busy, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_start_busy();
        test_zero_len();
        test_reset_mid();
        test_max_len();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
